inst_queue: RTL and testbench

- Dual-width instruction FIFO between the fetch stage and the dual-issue decode stage.
- Accepts 0–2 fetched instructions per cycle from fetch.
- Presents the two oldest entries to decode and retires 1 or 2 per cycle, according to decode's issue decision.
- Decouples I-cache latency from decode stalls and drops all state on a pipeline flush.

---
 rtl/inst_queue_pkg.sv | 18 +
 rtl/inst_queue_if.sv | 39 +++
 rtl/inst_queue_ram.sv | 35 +++
 rtl/inst_queue.sv | 117 +++++++++++
 tb/tb_inst_queue.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/inst_queue_pkg.sv
// Shared constants and entry layout for the dual-width instruction queue.
package inst_queue_pkg;

  localparam int IQ_DEPTH    = 16;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic DualIssue   = 1'b1;
  localparam logic SingleIssue = 1'b0;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  typedef struct packed {
    logic [InstAddrBus-1:0] addr;
    logic [InstBus-1:0]     inst;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side push bus plus decode-side view of the two oldest entries.
// Fetch pushes only while full_o = 0; decode consumes inst*_valid_o slots unless stall = 1.
interface inst_queue_if #(
  parameter int PTR_W = 4
);

  logic              stall;
  logic              issue_i;
  logic              inst1_valid_i;
  logic              inst2_valid_i;
  logic [31:0]       inst1_addr_i;
  logic [31:0]       inst1_i;
  logic [31:0]       inst2_addr_i;
  logic [31:0]       inst2_i;

  logic              full_o;
  logic              inst1_valid_o;
  logic              inst2_valid_o;
  logic [31:0]       inst1_addr_o;
  logic [31:0]       inst1_o;
  logic [31:0]       inst2_addr_o;
  logic [31:0]       inst2_o;
  logic [PTR_W:0]    count_o;

  modport master (
    output stall, issue_i, inst1_valid_i, inst2_valid_i,
           inst1_addr_i, inst1_i, inst2_addr_i, inst2_i,
    input  full_o, inst1_valid_o, inst2_valid_o,
           inst1_addr_o, inst1_o, inst2_addr_o, inst2_o, count_o
  );

  modport slave (
    input  stall, issue_i, inst1_valid_i, inst2_valid_i,
           inst1_addr_i, inst1_i, inst2_addr_i, inst2_i,
    output full_o, inst1_valid_o, inst2_valid_o,
           inst1_addr_o, inst1_o, inst2_addr_o, inst2_o, count_o
  );

endinterface

// File: rtl/inst_queue_ram.sv
// iq_ram: un-reset entry array with two contiguous write ports and two contiguous read ports.
// Second port of each pair addresses base+1, wrapping naturally at DEPTH.
module iq_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0_i,
  input  logic             we1_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  iq_entry_t        wdata0_i,
  input  iq_entry_t        wdata1_i,
  input  logic [PTR_W-1:0] raddr_i,
  output iq_entry_t        rdata0_o,
  output iq_entry_t        rdata1_o
);

  iq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] waddr1;
  logic [PTR_W-1:0] raddr1;

  assign waddr1 = waddr_i + PTR_W'(1);
  assign raddr1 = raddr_i + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (we0_i) mem_q[waddr_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1]  <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr_i];
  assign rdata1_o = mem_q[raddr1];

endmodule

// File: rtl/inst_queue.sv
// Dual-width instruction FIFO between fetch and dual-issue decode.
// Build option IQ_BYPASS_EN: when empty, fetch slots feed decode in the same cycle.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  inst_queue_if.slave  iq
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic      full;
  logic      kill;
  logic      bypass;
  logic [1:0] lim, avail, push_n, pop_n, bp_n, wr_n;
  logic      we0, we1;
  iq_entry_t slot1, slot2, wdata0, rdata0, rdata1;

  assign full  = count_q > (PTR_W+1)'(DEPTH-2);
  assign kill  = resetn | flush;
  assign slot1 = '{addr: iq.inst1_addr_i, inst: iq.inst1_i};
  assign slot2 = '{addr: iq.inst2_addr_i, inst: iq.inst2_i};

  always_comb begin
    lim    = (iq.issue_i == DualIssue) ? 2'd2 : 2'd1;
    avail  = (count_q >= (PTR_W+1)'(2)) ? 2'd2 : count_q[1:0];
    push_n = 2'd0;
    pop_n  = 2'd0;
    bp_n   = 2'd0;
    bypass = 1'b0;
    if (!full && !kill && iq.inst1_valid_i)
      push_n = iq.inst2_valid_i ? 2'd2 : 2'd1;
    if (!kill && !iq.stall)
      pop_n = (avail < lim) ? avail : lim;
`ifdef IQ_BYPASS_EN
    // Slots retired straight from fetch never occupy storage.
    bypass = (count_q == '0) && !kill;
    if (bypass && !iq.stall)
      bp_n = (push_n < lim) ? push_n : lim;
`endif
    wr_n = push_n - bp_n;
  end

  assign we0    = wr_n != 2'd0;
  assign we1    = wr_n == 2'd2;
  assign wdata0 = (bp_n == 2'd1) ? slot2 : slot1;

  always_comb begin
    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(wr_n);
    count_d = count_q + (PTR_W+1)'(wr_n) - (PTR_W+1)'(pop_n);
    if (kill) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  iq_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk      (clk),
    .we0_i    (we0),
    .we1_i    (we1),
    .waddr_i  (tail_q),
    .wdata0_i (wdata0),
    .wdata1_i (slot2),
    .raddr_i  (head_q),
    .rdata0_o (rdata0),
    .rdata1_o (rdata1)
  );

  always_comb begin
    iq.full_o        = full;
    iq.count_o       = count_q;
    iq.inst1_valid_o = count_q >= (PTR_W+1)'(1);
    iq.inst2_valid_o = count_q >= (PTR_W+1)'(2);
    iq.inst1_addr_o  = rdata0.addr;
    iq.inst1_o       = rdata0.inst;
    iq.inst2_addr_o  = rdata1.addr;
    iq.inst2_o       = rdata1.inst;
    if (bypass) begin
      iq.inst1_valid_o = iq.inst1_valid_i;
      iq.inst2_valid_o = iq.inst1_valid_i & iq.inst2_valid_i;
      iq.inst1_addr_o  = slot1.addr;
      iq.inst1_o       = slot1.inst;
      iq.inst2_addr_o  = slot2.addr;
      iq.inst2_o       = slot2.inst;
    end
    if (!iq.inst1_valid_o) begin
      iq.inst1_addr_o = ZeroWord;
      iq.inst1_o      = ZeroWord;
    end
    if (!iq.inst2_valid_o) begin
      iq.inst2_addr_o = ZeroWord;
      iq.inst2_o      = ZeroWord;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Randomised and directed bench for inst_queue against a list-based reference model.
module tb_inst_queue;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  localparam int W     = 136;

  logic clk;
  logic resetn;
  logic flush;

  inst_queue_if #(.PTR_W(PTR_W)) iq ();

  inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .iq     (iq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [63:0]  model_q[$];
  int checks = 0;
  int errors = 0;

  // monitor / scoreboard: one expected snapshot per checked cycle
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({iq.inst1_valid_o, iq.inst2_valid_o} !== e[135:134]) begin
        errors++;
        $display("FAIL valid: got %b required %b", {iq.inst1_valid_o, iq.inst2_valid_o}, e[135:134]);
      end
      checks++;
      if ({iq.inst1_addr_o, iq.inst1_o} !== e[133:70]) begin
        errors++;
        $display("FAIL slot1: got %h required %h", {iq.inst1_addr_o, iq.inst1_o}, e[133:70]);
      end
      checks++;
      if ({iq.inst2_addr_o, iq.inst2_o} !== e[69:6]) begin
        errors++;
        $display("FAIL slot2: got %h required %h", {iq.inst2_addr_o, iq.inst2_o}, e[69:6]);
      end
      checks++;
      if (iq.count_o !== e[5:1]) begin
        errors++;
        $display("FAIL count: got %0d required %0d", iq.count_o, e[5:1]);
      end
      checks++;
      if (iq.full_o !== e[0]) begin
        errors++;
        $display("FAIL full: got %b required %b", iq.full_o, e[0]);
      end
    end
  end

  // driver: one clock cycle of stimulus, expectation and model update
  task automatic cycle(input logic v1, input logic v2,
                       input logic [31:0] a1, input logic [31:0] a2,
                       input logic st, input logic is, input logic fl,
                       input logic rs, input bit chk);
    logic [63:0] incoming[$];
    logic        e_v1, e_v2, e_full;
    logic [63:0] e_s1, e_s2;
    int          n, lim;
    bit          byp;
    iq.inst1_valid_i = v1;
    iq.inst2_valid_i = v2;
    iq.inst1_addr_i  = a1;
    iq.inst1_i       = a1 ^ 32'hdead_beef;
    iq.inst2_addr_i  = a2;
    iq.inst2_i       = a2 ^ 32'hdead_beef;
    iq.stall         = st;
    iq.issue_i       = is;
    flush            = fl;
    resetn           = rs;

    n      = model_q.size();
    e_full = (n >= DEPTH - 1);
    byp    = 1'b0;
`ifdef IQ_BYPASS_EN
    byp = (n == 0) && !fl && !rs;
`endif
    if (byp) begin
      e_v1 = v1;
      e_v2 = v1 && v2;
      e_s1 = e_v1 ? {a1, a1 ^ 32'hdead_beef} : 64'h0;
      e_s2 = e_v2 ? {a2, a2 ^ 32'hdead_beef} : 64'h0;
    end else begin
      e_v1 = n >= 1;
      e_v2 = n >= 2;
      e_s1 = e_v1 ? model_q[0] : 64'h0;
      e_s2 = e_v2 ? model_q[1] : 64'h0;
    end
    if (chk) exp_q.push_back({e_v1, e_v2, e_s1, e_s2, 5'(n), e_full});

    @(posedge clk);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (!e_full && v1) begin
        incoming.push_back({a1, a1 ^ 32'hdead_beef});
        if (v2) incoming.push_back({a2, a2 ^ 32'hdead_beef});
      end
      lim = is ? 2 : 1;
      if (!st) begin
        for (int k = 0; k < lim; k++) begin
          if (byp) begin
            if (incoming.size() > 0) void'(incoming.pop_front());
          end else if (model_q.size() > 0) begin
            void'(model_q.pop_front());
          end
        end
      end
      foreach (incoming[k]) model_q.push_back(incoming[k]);
    end
    #1;
  endtask

  task automatic idle(input logic st, input logic is);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, st, is, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push2(input logic [31:0] a, input logic st, input logic is);
    cycle(1'b1, 1'b1, a, a + 32'd4, st, is, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push1(input logic [31:0] a, input logic st, input logic is);
    cycle(1'b1, 1'b0, a, 32'h0, st, is, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    resetn = 1'b1;
    flush  = 1'b0;
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // fill to full, then refuse further pushes, then drain
    for (int k = 0; k < 8; k++) push2(32'hBFC0_0000 + 32'(8 * k), 1'b1, 1'b0);
    push2(32'hBFC0_1000, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) idle(1'b0, 1'b1);

    // dual retire with only one entry left must not underflow
    do_reset();
    push2(32'h100, 1'b1, 1'b0);
    push1(32'h108, 1'b1, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);

    // move head/tail to DEPTH-1 then dual push across the wrap
    do_reset();
    for (int k = 0; k < DEPTH - 1; k++) push1(32'h1000 + 32'(4 * k), 1'b1, 1'b0);
    for (int k = 0; k < DEPTH - 1; k++) idle(1'b0, 1'b0);
    push2(32'h200, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) idle(1'b0, 1'b0);

    // simultaneous push and pop at count 5
    do_reset();
    push2(32'h400, 1'b1, 1'b0);
    push2(32'h408, 1'b1, 1'b0);
    push1(32'h410, 1'b1, 1'b0);
    push2(32'h500, 1'b0, 1'b0);
    idle(1'b1, 1'b0);

    // flush beats stall and push
    do_reset();
    for (int k = 0; k < 3; k++) push2(32'h600 + 32'(8 * k), 1'b1, 1'b0);
    push1(32'h618, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h700, 32'h704, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b0);

    // empty-queue dual push with dual issue
    do_reset();
    idle(1'b1, 1'b0);
    push2(32'h300, 1'b0, 1'b1);
    idle(1'b1, 1'b0);

    // randomised traffic with occasional flush and reset
    for (int k = 0; k < 3000; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            $urandom() & 32'hffff_fffc, $urandom() & 32'hffff_fffc,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 200) == 0), 1'b1);
    end
    idle(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
